loop_sequencer: RTL and testbench
=================================

LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 SHALL have parameter NUM_MAX_LOOPS, default 7, the number of loop levels (level 0 outermost).
REQ-002 SHALL have parameter LOG_NUM_MAX_LOOPS, default 3, the width of the level index.
REQ-003 SHALL have parameter BASE_WIDTH, default 32, the width of the base and stride.
REQ-004 SHALL have parameter NUM_ITER_WIDTH, default 32, the width of a per-level iteration count.
REQ-005 SHALL have parameter TOTAL_WIDTH, default 64, the width of the total address count.
REQ-006 SHALL use one clock and a synchronous, active-high reset, as listed in REQ-007 and REQ-008.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port cfg_valid, input, 1 bit: writes one level's configuration.
REQ-010 SHALL have port cfg_level, input, LOG_NUM_MAX_LOOPS bits: the level index being written.
REQ-011 SHALL have port cfg_stride, input, BASE_WIDTH bits: the stride for that level.
REQ-012 SHALL have port cfg_num_iter, input, NUM_ITER_WIDTH bits: the iteration count for that level.
REQ-013 SHALL have port cfg_base_valid, input, 1 bit: writes the base register.
REQ-014 SHALL have port cfg_base, input, BASE_WIDTH bits: the start address.
REQ-015 SHALL have port cmd_start, input, 1 bit: requests a loop run.
REQ-016 SHALL have port cmd_abort, input, 1 bit: cancels the current run.
REQ-017 SHALL have port cmd_ready, output, 1 bit: high in IDLE.
REQ-018 SHALL have port gen_base, output, BASE_WIDTH bits: the base driven to the address generator.
REQ-019 SHALL have port gen_stride, output, BASE_WIDTH*NUM_MAX_LOOPS bits: the flattened strides, level i at bits [i*BASE_WIDTH +: BASE_WIDTH].
REQ-020 SHALL have port gen_num_iter, output, NUM_ITER_WIDTH*NUM_MAX_LOOPS bits: the flattened iteration counts, packed like gen_stride.
REQ-021 SHALL have port gen_start, output, 1 bit: a one-cycle start pulse to the generator.
REQ-022 SHALL have port gen_in_loop, output, 1 bit: a level signal that is high while the generator runs.
REQ-023 SHALL have port gen_addr_valid, input, 1 bit: the generator's address-valid strobe.
REQ-024 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-025 SHALL have port done, output, 1 bit: a one-cycle pulse when a run completes.
REQ-026 SHALL have port aborted, output, 1 bit: a one-cycle pulse when a run is aborted.
REQ-027 SHALL have port cfg_err, output, 1 bit: a one-cycle pulse when a write is rejected.
REQ-028 SHALL have port addr_count, output, TOTAL_WIDTH bits: the number of addresses counted in the current or last run.

Function
REQ-029 SHALL implement the FSM states IDLE, CALC, START, RUN and DONE.
REQ-030 SHALL accept cfg_valid and cfg_base_valid only in IDLE.
REQ-031 SHALL ignore cfg_valid or cfg_base_valid in other states and pulse cfg_err in the following cycle.
REQ-032 SHALL ignore cfg_level >= NUM_MAX_LOOPS and pulse cfg_err.
REQ-033 SHALL, when cfg_valid and cmd_start coincide in IDLE, commit the write and have it used by that run.
REQ-034 SHALL move from IDLE to CALC on cmd_start and clear addr_count to 0 on that transition.
REQ-035 SHALL, in CALC, compute total = product of eff_i over levels 0..NUM_MAX_LOOPS-1, one level per cycle, in exactly NUM_MAX_LOOPS cycles.
REQ-036 SHALL define eff_i as 1 when num_iter_i is 0, and num_iter_i otherwise.
REQ-037 SHALL compute the product modulo 2^TOTAL_WIDTH, with each operand zero-extended.
REQ-038 SHALL move from CALC to START, assert gen_start for exactly one cycle in START, then move to RUN.
REQ-039 SHALL hold gen_in_loop high in START and RUN, and low otherwise.
REQ-040 SHALL, in RUN, increment addr_count by 1 on each cycle with gen_addr_valid high; gen_addr_valid outside RUN is ignored.
REQ-041 SHALL move from RUN to DONE on the cycle addr_count+1 == total with gen_addr_valid high.
REQ-042 SHALL pulse done for one cycle in DONE, then return to IDLE.
REQ-043 SHALL hold addr_count until the next cmd_start.
REQ-044 SHALL ignore cmd_start when not in IDLE.
REQ-045 SHALL, on cmd_abort in CALC, START or RUN, go to IDLE next cycle, drop gen_in_loop and gen_start, pulse aborted, and not pulse done.
REQ-046 SHALL give cmd_abort priority over completion when both occur in the same cycle.
REQ-047 SHALL drive gen_base, gen_stride and gen_num_iter directly from the config registers, stable throughout a run.
REQ-048 SHALL never assert gen_start when not in START.

Reset
REQ-049 SHALL apply reset synchronously, overriding all other inputs, and return to IDLE from any state, including mid-run.
REQ-050 SHALL reset to: strides 0, num_iter 1 per level, base 0, addr_count 0, total 1.
REQ-051 SHALL reset all pulse outputs and gen_in_loop to 0, with cmd_ready 1 and busy 0 in the cycle after reset deasserts.

Structure
REQ-052 SHALL place the FSM state encoding and the default widths in a shared simd_pkg package.
REQ-053 SHALL use one sub-module, loop_total_calc, the sequential multiply-accumulate for CALC with start, level-select and done outputs.
REQ-054 SHALL implement the config registers and FSM in this module, with no combinational path from gen_addr_valid to gen_start.

Verification
REQ-055 SHALL cover: num_iter {2,3,4,1,1,1,1}, base 0x100, start -> gen_start one pulse at cycle 8 after start, done after 24 valids, addr_count=24.
REQ-056 SHALL cover: all num_iter 0 -> total 1, done after the first valid, addr_count=1.
REQ-057 SHALL cover: cfg_valid level 2 in RUN -> cfg_err pulse, gen_num_iter unchanged; cfg_level=7 in IDLE -> cfg_err, no write.
REQ-058 SHALL cover: cmd_abort on the same cycle as the 24th valid -> aborted pulse, no done, IDLE next cycle.
REQ-059 SHALL cover: reset asserted in RUN after 10 valids -> IDLE, addr_count 0, gen_num_iter all 1, gen_in_loop 0.
REQ-060 SHALL cover: back-to-back runs, with cmd_start on the cycle after done -> second run accepted, addr_count restarts at 0.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared defaults and FSM encoding for the loop sequencer and its total calculator.
package simd_pkg;

    localparam int DEF_NUM_MAX_LOOPS     = 7;
    localparam int DEF_LOG_NUM_MAX_LOOPS = 3;
    localparam int DEF_BASE_WIDTH        = 32;
    localparam int DEF_NUM_ITER_WIDTH    = 32;
    localparam int DEF_TOTAL_WIDTH       = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CALC  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    // States in which a run is in flight and may be cancelled.
    function automatic logic run_active(seq_state_t s);
        return (s == ST_CALC) || (s == ST_START) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/loop_sequencer_if.sv
// Configuration, command and address-generator signals of the loop sequencer.
interface loop_sequencer_if
    import simd_pkg::*;
#(
    parameter int NUM_MAX_LOOPS     = DEF_NUM_MAX_LOOPS,
    parameter int LOG_NUM_MAX_LOOPS = DEF_LOG_NUM_MAX_LOOPS,
    parameter int BASE_WIDTH        = DEF_BASE_WIDTH,
    parameter int NUM_ITER_WIDTH    = DEF_NUM_ITER_WIDTH,
    parameter int TOTAL_WIDTH       = DEF_TOTAL_WIDTH
) ();

    logic                                cfg_valid;
    logic [LOG_NUM_MAX_LOOPS-1:0]        cfg_level;
    logic [BASE_WIDTH-1:0]               cfg_stride;
    logic [NUM_ITER_WIDTH-1:0]           cfg_num_iter;
    logic                                cfg_base_valid;
    logic [BASE_WIDTH-1:0]               cfg_base;
    logic                                cmd_start;
    logic                                cmd_abort;
    logic                                cmd_ready;
    logic [BASE_WIDTH-1:0]               gen_base;
    logic [BASE_WIDTH*NUM_MAX_LOOPS-1:0] gen_stride;
    logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0] gen_num_iter;
    logic                                gen_start;
    logic                                gen_in_loop;
    logic                                gen_addr_valid;
    logic                                busy;
    logic                                done;
    logic                                aborted;
    logic                                cfg_err;
    logic [TOTAL_WIDTH-1:0]              addr_count;

    modport master (
        output cfg_valid, cfg_level, cfg_stride, cfg_num_iter,
        output cfg_base_valid, cfg_base,
        output cmd_start, cmd_abort,
        output gen_addr_valid,
        input  cmd_ready, gen_base, gen_stride, gen_num_iter,
        input  gen_start, gen_in_loop,
        input  busy, done, aborted, cfg_err, addr_count
    );

    modport slave (
        input  cfg_valid, cfg_level, cfg_stride, cfg_num_iter,
        input  cfg_base_valid, cfg_base,
        input  cmd_start, cmd_abort,
        input  gen_addr_valid,
        output cmd_ready, gen_base, gen_stride, gen_num_iter,
        output gen_start, gen_in_loop,
        output busy, done, aborted, cfg_err, addr_count
    );

endinterface

// File: rtl/loop_total_calc.sv
// Sequential product of the per-level effective iteration counts, one level per cycle.
module loop_total_calc
    import simd_pkg::*;
#(
    parameter int NUM_MAX_LOOPS     = DEF_NUM_MAX_LOOPS,
    parameter int LOG_NUM_MAX_LOOPS = DEF_LOG_NUM_MAX_LOOPS,
    parameter int NUM_ITER_WIDTH    = DEF_NUM_ITER_WIDTH,
    parameter int TOTAL_WIDTH       = DEF_TOTAL_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         cancel,
    input  logic [NUM_ITER_WIDTH-1:0]    num_iter,
    output logic [LOG_NUM_MAX_LOOPS-1:0] level,
    output logic                         done,
    output logic [TOTAL_WIDTH-1:0]       total
);

    localparam logic [LOG_NUM_MAX_LOOPS-1:0] LAST_LEVEL =
        LOG_NUM_MAX_LOOPS'(NUM_MAX_LOOPS - 1);

    logic                   active;
    logic [TOTAL_WIDTH-1:0] eff;

    // A zero count means the level is unused and contributes a factor of one.
    assign eff  = (num_iter == '0) ? TOTAL_WIDTH'(1) : TOTAL_WIDTH'(num_iter);
    assign done = active && (level == LAST_LEVEL);

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            level  <= '0;
            total  <= TOTAL_WIDTH'(1);
        end else if (cancel) begin
            active <= 1'b0;
            level  <= '0;
        end else if (start) begin
            active <= 1'b1;
            level  <= '0;
            total  <= TOTAL_WIDTH'(1);
        end else if (active) begin
            total <= total * eff;
            if (done) begin
                active <= 1'b0;
                level  <= '0;
            end else begin
                level <= level + LOG_NUM_MAX_LOOPS'(1);
            end
        end
    end

endmodule

// File: rtl/loop_sequencer.sv
// Holds the loop configuration, sizes the run, and sequences the address generator.
module loop_sequencer
    import simd_pkg::*;
#(
    parameter int NUM_MAX_LOOPS     = DEF_NUM_MAX_LOOPS,
    parameter int LOG_NUM_MAX_LOOPS = DEF_LOG_NUM_MAX_LOOPS,
    parameter int BASE_WIDTH        = DEF_BASE_WIDTH,
    parameter int NUM_ITER_WIDTH    = DEF_NUM_ITER_WIDTH,
    parameter int TOTAL_WIDTH       = DEF_TOTAL_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    loop_sequencer_if.slave bus
);

    seq_state_t                    state;
    logic [BASE_WIDTH-1:0]         base_q;
    logic [BASE_WIDTH-1:0]         stride_q   [NUM_MAX_LOOPS];
    logic [NUM_ITER_WIDTH-1:0]     num_iter_q [NUM_MAX_LOOPS];
    logic [TOTAL_WIDTH-1:0]        addr_count_q;
    logic [TOTAL_WIDTH-1:0]        total;
    logic                          cmd_ready_q;
    logic                          busy_q;
    logic                          gen_start_q;
    logic                          gen_in_loop_q;
    logic                          done_q;
    logic                          aborted_q;
    logic                          cfg_err_q;
    logic                          level_ok;
    logic                          cfg_write;
    logic                          base_write;
    logic                          calc_start;
    logic                          calc_cancel;
    logic                          calc_done;
    logic [LOG_NUM_MAX_LOOPS-1:0]  calc_level;
    logic [BASE_WIDTH*NUM_MAX_LOOPS-1:0]     stride_flat;
    logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0] num_iter_flat;

    assign level_ok    = {1'b0, bus.cfg_level} < (LOG_NUM_MAX_LOOPS+1)'(NUM_MAX_LOOPS);
    assign cfg_write   = (state == ST_IDLE) && bus.cfg_valid && level_ok;
    assign base_write  = (state == ST_IDLE) && bus.cfg_base_valid;
    assign calc_start  = (state == ST_IDLE) && bus.cmd_start;
    assign calc_cancel = (state == ST_CALC) && bus.cmd_abort;

    loop_total_calc #(
        .NUM_MAX_LOOPS     (NUM_MAX_LOOPS),
        .LOG_NUM_MAX_LOOPS (LOG_NUM_MAX_LOOPS),
        .NUM_ITER_WIDTH    (NUM_ITER_WIDTH),
        .TOTAL_WIDTH       (TOTAL_WIDTH)
    ) u_total_calc (
        .clk      (clk),
        .reset    (reset),
        .start    (calc_start),
        .cancel   (calc_cancel),
        .num_iter (num_iter_q[calc_level]),
        .level    (calc_level),
        .done     (calc_done),
        .total    (total)
    );

    // A write coinciding with cmd_start lands before the calculator reads level 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
                stride_q[i]   <= '0;
                num_iter_q[i] <= NUM_ITER_WIDTH'(1);
            end
        end else begin
            if (base_write) begin
                base_q <= bus.cfg_base;
            end
            if (cfg_write) begin
                stride_q[bus.cfg_level]   <= bus.cfg_stride;
                num_iter_q[bus.cfg_level] <= bus.cfg_num_iter;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr_count_q  <= '0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            gen_start_q   <= 1'b0;
            gen_in_loop_q <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            gen_start_q <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            cfg_err_q   <= ((state != ST_IDLE) && (bus.cfg_valid || bus.cfg_base_valid)) ||
                           ((state == ST_IDLE) && bus.cfg_valid && !level_ok);
            // Abort outranks completion, including a final valid in the same cycle.
            if (run_active(state) && bus.cmd_abort) begin
                state         <= ST_IDLE;
                gen_in_loop_q <= 1'b0;
                aborted_q     <= 1'b1;
                cmd_ready_q   <= 1'b1;
                busy_q        <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.cmd_start) begin
                            state        <= ST_CALC;
                            addr_count_q <= '0;
                            cmd_ready_q  <= 1'b0;
                            busy_q       <= 1'b1;
                        end
                    end
                    ST_CALC: begin
                        if (calc_done) begin
                            state         <= ST_START;
                            gen_start_q   <= 1'b1;
                            gen_in_loop_q <= 1'b1;
                        end
                    end
                    ST_START: begin
                        state <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (bus.gen_addr_valid) begin
                            addr_count_q <= addr_count_q + TOTAL_WIDTH'(1);
                            if ((addr_count_q + TOTAL_WIDTH'(1)) == total) begin
                                state         <= ST_DONE;
                                done_q        <= 1'b1;
                                gen_in_loop_q <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: begin
                        state       <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                    default: begin
                        state         <= ST_IDLE;
                        gen_in_loop_q <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        busy_q        <= 1'b0;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_MAX_LOOPS; g++) begin : g_flat
        assign stride_flat[g*BASE_WIDTH +: BASE_WIDTH]           = stride_q[g];
        assign num_iter_flat[g*NUM_ITER_WIDTH +: NUM_ITER_WIDTH] = num_iter_q[g];
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.busy         = busy_q;
    assign bus.gen_base     = base_q;
    assign bus.gen_stride   = stride_flat;
    assign bus.gen_num_iter = num_iter_flat;
    assign bus.gen_start    = gen_start_q;
    assign bus.gen_in_loop  = gen_in_loop_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.addr_count   = addr_count_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer; run endings are scored against a queue of expectations.
module tb_loop_sequencer;
    import simd_pkg::*;

    localparam int N   = 7;
    localparam int LW  = 3;
    localparam int BW  = 32;
    localparam int NW  = 32;
    localparam int TW  = 64;

    typedef struct packed {
        logic          was_abort;
        logic [TW-1:0] count;
    } sb_entry_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    loop_sequencer_if #(
        .NUM_MAX_LOOPS(N), .LOG_NUM_MAX_LOOPS(LW), .BASE_WIDTH(BW),
        .NUM_ITER_WIDTH(NW), .TOTAL_WIDTH(TW)
    ) bus ();

    loop_sequencer #(
        .NUM_MAX_LOOPS(N), .LOG_NUM_MAX_LOOPS(LW), .BASE_WIDTH(BW),
        .NUM_ITER_WIDTH(NW), .TOTAL_WIDTH(TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sb_entry_t      sb_q[$];
    int             checks    = 0;
    int             passed    = 0;
    int             failed    = 0;
    int             ends_seen = 0;
    logic [NW-1:0]  m_niter  [N];
    logic [BW-1:0]  m_stride [N];

    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [NW*N-1:0] flatNiter();
        logic [NW*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*NW +: NW] = m_niter[i];
        return v;
    endfunction

    function automatic logic [BW*N-1:0] flatStride();
        logic [BW*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*BW +: BW] = m_stride[i];
        return v;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            m_niter[i]  = NW'(1);
            m_stride[i] = '0;
        end
    endtask

    task automatic writeLevel(input int lvl, input logic [BW-1:0] stride,
                              input logic [NW-1:0] niter, input bit accept);
        bus.cfg_valid    = 1'b1;
        bus.cfg_level    = LW'(lvl);
        bus.cfg_stride   = stride;
        bus.cfg_num_iter = niter;
        if (accept) begin
            m_niter[lvl]  = niter;
            m_stride[lvl] = stride;
        end
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic applyStimulus(input bit expect_end, input bit was_abort,
                                 input logic [TW-1:0] count);
        sb_entry_t e;
        if (expect_end) begin
            e.was_abort = was_abort;
            e.count     = count;
            sb_q.push_back(e);
        end
        bus.cmd_start = 1'b1;
        @(negedge clk);
        bus.cmd_start = 1'b0;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pumpValids(input int n);
        for (int i = 0; i < n; i++) begin
            bus.gen_addr_valid = 1'b1;
            @(negedge clk);
        end
        bus.gen_addr_valid = 1'b0;
    endtask

    task automatic waitEnd(input int base, input int budget);
        int n = 0;
        while (ends_seen == base && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("end_seen", 256'(ends_seen - base), 256'd1);
    endtask

    always begin
        @(posedge clk);
        #2;
        if (reset === 1'b0 && (bus.done === 1'b1 || bus.aborted === 1'b1)) begin
            ends_seen++;
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_end", {bus.done, bus.aborted}, 2'b00);
            end else begin
                sb_entry_t e;
                e = sb_q.pop_front();
                checkOutput("sb_end_kind", {bus.done, bus.aborted}, {~e.was_abort, e.was_abort});
                if (!e.was_abort) checkOutput("sb_addr_count", bus.addr_count, e.count);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base_ends;
        int first_k;
        int highs;
        logic [NW-1:0] niter_a [N];
        niter_a = '{NW'(2), NW'(3), NW'(4), NW'(1), NW'(1), NW'(1), NW'(1)};

        reset              = 1'b1;
        bus.cfg_valid      = 1'b0;
        bus.cfg_level      = '0;
        bus.cfg_stride     = '0;
        bus.cfg_num_iter   = '0;
        bus.cfg_base_valid = 1'b0;
        bus.cfg_base       = '0;
        bus.cmd_start      = 1'b0;
        bus.cmd_abort      = 1'b0;
        bus.gen_addr_valid = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_cmd_ready", bus.cmd_ready, 1'b1);
        checkOutput("rst_busy", bus.busy, 1'b0);
        checkOutput("rst_gen_in_loop", bus.gen_in_loop, 1'b0);
        checkOutput("rst_addr_count", bus.addr_count, 64'd0);
        checkOutput("rst_gen_num_iter", bus.gen_num_iter, flatNiter());
        checkOutput("rst_gen_stride", bus.gen_stride, flatStride());
        checkOutput("rst_gen_base", bus.gen_base, 32'd0);

        $display("[TB] run with num_iter {2,3,4,1,1,1,1}, base 0x100");
        for (int i = 0; i < N; i++) writeLevel(i, BW'((i + 1) * 16), niter_a[i], 1'b1);
        bus.cfg_base_valid = 1'b1;
        bus.cfg_base       = 32'h100;
        @(negedge clk);
        bus.cfg_base_valid = 1'b0;
        checkOutput("cfg_gen_num_iter", bus.gen_num_iter, flatNiter());
        checkOutput("cfg_gen_stride", bus.gen_stride, flatStride());
        checkOutput("cfg_gen_base", bus.gen_base, 32'h100);
        base_ends = ends_seen;
        applyStimulus(1'b1, 1'b0, 64'd24);
        first_k = 0;
        highs   = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.gen_start === 1'b1) begin
                highs++;
                if (first_k == 0) first_k = k;
            end
            if (k == 1) begin
                checkOutput("calc_busy", bus.busy, 1'b1);
                checkOutput("calc_cmd_ready", bus.cmd_ready, 1'b0);
                checkOutput("calc_gen_in_loop", bus.gen_in_loop, 1'b0);
            end
            if (k == 8) checkOutput("start_gen_in_loop", bus.gen_in_loop, 1'b1);
        end
        checkOutput("gen_start_cycle", 256'(first_k), 256'd8);
        checkOutput("gen_start_width", 256'(highs), 256'd1);
        pumpValids(24);
        checkOutput("run1_done", bus.done, 1'b1);
        checkOutput("run1_in_loop_low", bus.gen_in_loop, 1'b0);
        waitEnd(base_ends, 5);
        @(negedge clk);
        checkOutput("run1_done_one_cycle", bus.done, 1'b0);
        checkOutput("run1_idle_ready", bus.cmd_ready, 1'b1);
        checkOutput("run1_count_held", bus.addr_count, 64'd24);

        $display("[TB] run with every num_iter 0 and rejected writes");
        for (int i = 0; i < N; i++) writeLevel(i, BW'((i + 1) * 16), NW'(0), 1'b1);
        checkOutput("zero_gen_num_iter", bus.gen_num_iter, flatNiter());
        base_ends = ends_seen;
        applyStimulus(1'b1, 1'b0, 64'd1);
        repeat (8) @(negedge clk);
        checkOutput("zero_in_run", bus.gen_in_loop, 1'b1);
        writeLevel(2, 32'h77, NW'(5), 1'b0);
        checkOutput("run_cfg_err", bus.cfg_err, 1'b1);
        checkOutput("run_cfg_no_write", bus.gen_num_iter, flatNiter());
        @(negedge clk);
        checkOutput("run_cfg_err_pulse", bus.cfg_err, 1'b0);
        pumpValids(1);
        checkOutput("zero_done", bus.done, 1'b1);
        waitEnd(base_ends, 5);
        @(negedge clk);
        writeLevel(7, 32'h55, NW'(9), 1'b0);
        checkOutput("lvl7_cfg_err", bus.cfg_err, 1'b1);
        checkOutput("lvl7_num_iter", bus.gen_num_iter, flatNiter());
        checkOutput("lvl7_stride", bus.gen_stride, flatStride());

        $display("[TB] abort together with the final valid");
        for (int i = 0; i < N; i++) writeLevel(i, BW'((i + 1) * 16), niter_a[i], 1'b1);
        base_ends = ends_seen;
        applyStimulus(1'b1, 1'b1, 64'd0);
        repeat (8) @(negedge clk);
        pumpValids(23);
        bus.gen_addr_valid = 1'b1;
        bus.cmd_abort      = 1'b1;
        @(negedge clk);
        bus.gen_addr_valid = 1'b0;
        bus.cmd_abort      = 1'b0;
        checkOutput("abort_pulse", bus.aborted, 1'b1);
        checkOutput("abort_no_done", bus.done, 1'b0);
        checkOutput("abort_idle", bus.cmd_ready, 1'b1);
        checkOutput("abort_busy", bus.busy, 1'b0);
        checkOutput("abort_in_loop", bus.gen_in_loop, 1'b0);
        waitEnd(base_ends, 5);
        @(negedge clk);
        checkOutput("abort_pulse_end", bus.aborted, 1'b0);
        checkOutput("abort_still_no_done", bus.done, 1'b0);

        $display("[TB] write coinciding with start, then back-to-back runs");
        bus.cfg_valid    = 1'b1;
        bus.cfg_level    = LW'(0);
        bus.cfg_stride   = 32'h10;
        bus.cfg_num_iter = NW'(1);
        m_niter[0]       = NW'(1);
        m_stride[0]      = 32'h10;
        base_ends = ends_seen;
        applyStimulus(1'b1, 1'b0, 64'd12);
        checkOutput("coincident_write", bus.gen_num_iter, flatNiter());
        repeat (8) @(negedge clk);
        pumpValids(12);
        checkOutput("b2b_first_done", bus.done, 1'b1);
        waitEnd(base_ends, 5);
        @(negedge clk);
        base_ends = ends_seen;
        applyStimulus(1'b1, 1'b0, 64'd12);
        checkOutput("b2b_accepted", bus.busy, 1'b1);
        checkOutput("b2b_count_cleared", bus.addr_count, 64'd0);
        repeat (8) @(negedge clk);
        pumpValids(12);
        waitEnd(base_ends, 5);
        @(negedge clk);

        $display("[TB] reset in the middle of a run");
        applyStimulus(1'b0, 1'b0, 64'd0);
        repeat (8) @(negedge clk);
        pumpValids(10);
        checkOutput("mid_count", bus.addr_count, 64'd10);
        checkOutput("mid_in_loop", bus.gen_in_loop, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        modelReset();
        checkOutput("mid_rst_count", bus.addr_count, 64'd0);
        checkOutput("mid_rst_num_iter", bus.gen_num_iter, flatNiter());
        checkOutput("mid_rst_in_loop", bus.gen_in_loop, 1'b0);
        checkOutput("mid_rst_base", bus.gen_base, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", bus.cmd_ready, 1'b1);
        checkOutput("post_rst_busy", bus.busy, 1'b0);
        checkOutput("post_rst_done", bus.done, 1'b0);

        checkOutput("sb_empty", 256'(sb_q.size()), 256'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
